// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  localparam int DEF_DATA_W    = 9;
  localparam int DEF_DIV_W     = 15;
  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  // Out-of-range widths are pulled into the supported window instead of rejected.
  function automatic logic [3:0] clampBits(input logic [3:0] cfg, input int maxBits);
    if (int'(cfg) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
    if (int'(cfg) > maxBits) return 4'(maxBits);
    return cfg;
  endfunction

  function automatic logic parityEnabled(input logic [1:0] mode);
    case (mode)
      PAR_EVEN, PAR_ODD:      return 1'b1;
      PAR_NONE, PAR_NONE_ALT: return 1'b0;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: ticks o_bit_end on the last clock of every D-clock bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_restart,
  output logic             o_bit_end
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  // Counter only reaches D-1, so D = 2^DIV_W-1 never wraps.
  assign w_last    = (r_cnt == i_div - DIV_W'(1));
  assign o_bit_end = w_last && !i_restart;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data width, parity, stop bits and baud divisor.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  state_e            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_nbits;
  logic [3:0]        r_bitIdx;
  logic              r_parEn;
  logic              r_parBit;
  logic              r_stop2;
  logic              r_stopCnt;
  logic [DIV_W-1:0]  r_div;
  logic              r_serial;
  logic              r_done;

  logic [3:0]        w_nbits;
  logic [DATA_W-1:0] w_mask;
  logic              w_xor;
  logic              w_bit_end;
  logic              w_restart;

  assign w_nbits = clampBits(cfg_data_bits, DATA_W);

  // Bits above the selected width are masked off at capture so neither
  // the serial stream nor the parity ever sees them.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_mask[i] = (i < int'(w_nbits));
    end
  end

  assign w_xor     = ^(tx_data & w_mask);
  assign w_restart = (r_state == IDLE);

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_div    (r_div),
    .i_restart(w_restart),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_nbits   <= '0;
      r_bitIdx  <= '0;
      r_parEn   <= 1'b0;
      r_parBit  <= 1'b0;
      r_stop2   <= 1'b0;
      r_stopCnt <= 1'b0;
      r_div     <= '0;
      r_serial  <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_serial <= 1'b1;
          if (tx_valid) begin
            r_shift  <= tx_data & w_mask;
            r_nbits  <= w_nbits;
            r_bitIdx <= '0;
            r_parEn  <= parityEnabled(cfg_parity);
            r_parBit <= (cfg_parity == PAR_ODD) ? ~w_xor : w_xor;
            r_stop2  <= cfg_stop2;
            r_div    <= (baud_div == '0) ? DIV_W'(1) : baud_div;
            r_serial <= 1'b0;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_serial <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bitIdx == r_nbits - 4'd1) begin
              r_stopCnt <= 1'b0;
              if (r_parEn) begin
                r_serial <= r_parBit;
                r_state  <= PARITY;
              end else begin
                r_serial <= 1'b1;
                r_state  <= STOP;
              end
            end else begin
              r_serial <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitIdx <= r_bitIdx + 4'd1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_serial  <= 1'b1;
            r_stopCnt <= 1'b0;
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (r_stop2 && !r_stopCnt) begin
              r_stopCnt <= 1'b1;
            end else begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_serial <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready  = (r_state == IDLE) && rst_n;
  assign tx_busy   = (r_state != IDLE);
  assign tx_serial = r_serial;
  assign tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg; frames are hand-encoded as
// bit vectors where bit i is the i-th transmitted bit (start bit at index 0).
module tb_uart_tx_cfg;

  logic        clk;
  logic        rst_n;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [14:0] baud_div;
  logic        tx_serial;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_cfg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .baud_div     (baud_div),
    .tx_serial    (tx_serial),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; the transfer lands on the following rising edge.
  task automatic applyStimulus(input logic [8:0] data, input logic [3:0] bits,
                               input logic [1:0] parity, input logic stop2,
                               input logic [14:0] div, input logic hold);
    int waitCnt;
    waitCnt       = 0;
    tx_data       = data;
    cfg_data_bits = bits;
    cfg_parity    = parity;
    cfg_stop2     = stop2;
    baud_div      = div;
    tx_valid      = 1'b1;
    while (!tx_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("tx_ready before transfer", 16'(tx_ready), 16'h1);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] frame,
                            input int nBits, input int d);
    for (int c = 0; c < nBits * d; c++) begin
      @(negedge clk);
      checkOutput({tag, " serial"}, 16'(tx_serial), 16'(frame[c / d]));
      checkOutput({tag, " done low"}, 16'(tx_done), 16'h0);
    end
    @(negedge clk);
    checkOutput({tag, " done pulse"}, 16'(tx_done), 16'h1);
    checkOutput({tag, " idle serial"}, 16'(tx_serial), 16'h1);
    checkOutput({tag, " idle busy"}, 16'(tx_busy), 16'h0);
    checkOutput({tag, " idle ready"}, 16'(tx_ready), 16'h1);
  endtask

  initial begin
    rst_n         = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    baud_div      = 15'd4;
    $display("[TB] starting uart_tx_cfg directed test");

    repeat (2) @(negedge clk);
    checkOutput("reset serial", 16'(tx_serial), 16'h1);
    checkOutput("reset ready", 16'(tx_ready), 16'h0);
    checkOutput("reset busy", 16'(tx_busy), 16'h0);
    checkOutput("reset done", 16'(tx_done), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready after reset", 16'(tx_ready), 16'h1);

    // 8N1, D=4, 0x55
    applyStimulus(9'h055, 4'd8, 2'b00, 1'b0, 15'd4, 1'b0);
    checkFrame("8N1 0x55", 16'h02AA, 10, 4);

    // 7E2, D=3, 0x07: parity 1, 11 bits
    applyStimulus(9'h007, 4'd7, 2'b01, 1'b1, 15'd3, 1'b0);
    checkFrame("7E2 0x07", 16'h070E, 11, 3);

    // 5O1, D=2, 0x3F: five ones, parity 0
    applyStimulus(9'h03F, 4'd5, 2'b10, 1'b0, 15'd2, 1'b0);
    checkFrame("5O1 0x3F", 16'h00BE, 8, 2);

    // 9N1, D=1, 0x1FF
    applyStimulus(9'h1FF, 4'd9, 2'b11, 1'b0, 15'd1, 1'b0);
    checkFrame("9N1 0x1FF", 16'h07FE, 11, 1);

    // width 2 clamps to 5; upper bits of 0x1E2 ignored
    applyStimulus(9'h1E2, 4'd2, 2'b00, 1'b0, 15'd1, 1'b0);
    checkFrame("clamp 5N1", 16'h0044, 7, 1);

    // Inputs changed mid-frame must not disturb the in-flight frame
    applyStimulus(9'h0A3, 4'd8, 2'b00, 1'b0, 15'd2, 1'b0);
    tx_data       = 9'h00B;
    cfg_data_bits = 4'd5;
    cfg_parity    = 2'b01;
    cfg_stop2     = 1'b1;
    baud_div      = 15'd5;
    checkFrame("inflight 8N1 0xA3", 16'h0346, 10, 2);
    applyStimulus(9'h00B, 4'd5, 2'b01, 1'b1, 15'd5, 1'b0);
    checkFrame("next 5E2 0x0B", 16'h01D6, 9, 5);

    // Reset during data bit 3 aborts the frame
    applyStimulus(9'h000, 4'd8, 2'b00, 1'b0, 15'd2, 1'b0);
    for (int c = 0; c < 9; c++) @(negedge clk);
    checkOutput("abort bit3 serial", 16'(tx_serial), 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort serial", 16'(tx_serial), 16'h1);
    checkOutput("abort done", 16'(tx_done), 16'h0);
    checkOutput("abort ready", 16'(tx_ready), 16'h0);
    checkOutput("abort busy", 16'(tx_busy), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release ready", 16'(tx_ready), 16'h1);
    checkOutput("release done", 16'(tx_done), 16'h0);
    checkOutput("release serial", 16'(tx_serial), 16'h1);
    @(negedge clk);
    checkOutput("release done later", 16'(tx_done), 16'h0);

    // Three back-to-back frames with baud_div=0 (1 clock per bit)
    applyStimulus(9'h015, 4'd5, 2'b00, 1'b0, 15'd0, 1'b1);
    checkFrame("b2b frame1", 16'h006A, 7, 1);
    applyStimulus(9'h015, 4'd5, 2'b00, 1'b0, 15'd0, 1'b1);
    checkFrame("b2b frame2", 16'h006A, 7, 1);
    applyStimulus(9'h015, 4'd5, 2'b00, 1'b0, 15'd0, 1'b0);
    checkFrame("b2b frame3", 16'h006A, 7, 1);
    @(negedge clk);
    checkOutput("after b2b busy", 16'(tx_busy), 16'h0);
    checkOutput("after b2b done", 16'(tx_done), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
